btb_update_queue: RTL and testbench

BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

---
 rtl/ariane_pkg.sv | 13 +
 rtl/btb_update_queue.sv | 106 ++++++++++
 tb/tb_btb_update_queue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Slice of the existing core packages this block depends on: the virtual
// address width and the BTB update record.
package riscv;
    localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic [riscv::VLEN-1:0] target_address;
    } btb_update_t;
endpackage

// File: rtl/btb_update_queue.sv
// Buffers resolved mispredictions and writes them into the BTB when allowed.
// Repeated offers for a queued pc update that entry's target in place.
module btb_update_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic                          flush_i,
    input  logic                          debug_mode_i,
    input  logic                          resolve_valid_i,
    input  logic [riscv::VLEN-1:0]        resolve_pc_i,
    input  logic [riscv::VLEN-1:0]        resolve_target_i,
    output logic                          resolve_ready_o,
    input  logic                          drain_en_i,
    output btb_update_t                   btb_update_o,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [riscv::VLEN-1:0] pc;
        logic [riscv::VLEN-1:0] target;
    } entry_t;

    entry_t             r_entries [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [OCC_W-1:0]   r_occ;

    logic               w_pop;
    logic               w_accept;
    logic               w_hit;
    logic [PTR_W-1:0]   w_hit_idx;

    // Ready comes from registered occupancy only, so a full queue stays
    // closed even in a cycle where it also pops.
    assign resolve_ready_o = (r_occ != OCC_W'(DEPTH));
    assign occupancy_o     = r_occ;

    assign w_pop    = (r_occ != '0) && drain_en_i && !debug_mode_i && !flush_i && !clr_i;
    assign w_accept = resolve_valid_i && resolve_ready_o && !debug_mode_i && !flush_i && !clr_i;

    // Walk from head (oldest) to youngest; a later match overrides an earlier one.
    // The head is skipped when it leaves this cycle so the update is not lost.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[r_head + PTR_W'(k)] && (k != 0 || !w_pop) &&
                r_entries[r_head + PTR_W'(k)].pc == resolve_pc_i) begin
                w_hit     = 1'b1;
                w_hit_idx = r_head + PTR_W'(k);
            end
        end
    end

    always_comb begin
        btb_update_o                = '0;
        btb_update_o.valid          = w_pop;
        btb_update_o.pc             = r_entries[r_head].pc;
        btb_update_o.target_address = r_entries[r_head].target;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
        end else if (clr_i) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
        end else if (flush_i) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_accept && w_hit) begin
                r_entries[w_hit_idx].target <= resolve_target_i;
            end else if (w_accept) begin
                r_entries[r_tail] <= '{pc: resolve_pc_i, target: resolve_target_i};
                r_valid[r_tail]   <= 1'b1;
                r_tail            <= r_tail + PTR_W'(1);
            end
            case ({w_accept && !w_hit, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: tb/tb_btb_update_queue.sv
// Directed vector table plus randomized traffic against a queue-based model
// of the BTB update queue.
module tb_btb_update_queue;
    localparam int DEPTH = 4;
    localparam int VLEN  = riscv::VLEN;
    localparam int OCC_W = $clog2(DEPTH+1);

    logic                     clk_i;
    logic                     rst_ni;
    logic                     clr_i;
    logic                     flush_i;
    logic                     debug_mode_i;
    logic                     resolve_valid_i;
    logic [VLEN-1:0]          resolve_pc_i;
    logic [VLEN-1:0]          resolve_target_i;
    logic                     resolve_ready_o;
    logic                     drain_en_i;
    ariane_pkg::btb_update_t  btb_update_o;
    logic [OCC_W-1:0]         occupancy_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: each element is {pc, target}, index 0 is the oldest entry.
    logic [2*VLEN-1:0] exp_q[$];

    typedef struct {
        logic            clr, flush, dbg, rv;
        logic [VLEN-1:0] pc, tgt;
        logic            drain;
        logic            e_ready, e_valid;
        logic [VLEN-1:0] e_pc, e_tgt;
        logic [OCC_W-1:0] e_occ;
    } vec_t;
    vec_t vecs[$];

    btb_update_queue #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clr_i            (clr_i),
        .flush_i          (flush_i),
        .debug_mode_i     (debug_mode_i),
        .resolve_valid_i  (resolve_valid_i),
        .resolve_pc_i     (resolve_pc_i),
        .resolve_target_i (resolve_target_i),
        .resolve_ready_o  (resolve_ready_o),
        .drain_en_i       (drain_en_i),
        .btb_update_o     (btb_update_o),
        .occupancy_o      (occupancy_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic c, input logic f, input logic d, input logic rv,
                         input logic [VLEN-1:0] pc, input logic [VLEN-1:0] tgt,
                         input logic dr);
        clr_i            = c;
        flush_i          = f;
        debug_mode_i     = d;
        resolve_valid_i  = rv;
        resolve_pc_i     = pc;
        resolve_target_i = tgt;
        drain_en_i       = dr;
    endtask

    task automatic check(input string name, input logic [VLEN-1:0] act,
                         input logic [VLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit pop, acc, hit;
        logic [2*VLEN-1:0] e;
        pop = (exp_q.size() != 0) && drain_en_i && !debug_mode_i && !flush_i && !clr_i;
        acc = resolve_valid_i && (exp_q.size() < DEPTH) && !debug_mode_i && !flush_i && !clr_i;
        hit = 0;
        if (clr_i || flush_i) begin
            exp_q.delete();
        end else begin
            if (acc) begin
                for (int k = exp_q.size() - 1; k >= (pop ? 1 : 0); k--) begin
                    if (!hit && exp_q[k][2*VLEN-1:VLEN] == resolve_pc_i) begin
                        e = exp_q[k];
                        e[VLEN-1:0] = resolve_target_i;
                        exp_q[k] = e;
                        hit = 1;
                    end
                end
            end
            if (pop) void'(exp_q.pop_front());
            if (acc && !hit) exp_q.push_back({resolve_pc_i, resolve_target_i});
        end
    endtask

    task automatic next_cycle();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic add_vec(input logic c, input logic f, input logic d, input logic rv,
                           input logic [VLEN-1:0] pc, input logic [VLEN-1:0] tgt,
                           input logic dr, input logic er, input logic ev,
                           input logic [VLEN-1:0] epc, input logic [VLEN-1:0] etg,
                           input int eocc);
        vec_t v;
        v.clr = c; v.flush = f; v.dbg = d; v.rv = rv; v.pc = pc; v.tgt = tgt;
        v.drain = dr; v.e_ready = er; v.e_valid = ev; v.e_pc = epc; v.e_tgt = etg;
        v.e_occ = OCC_W'(eocc);
        vecs.push_back(v);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [VLEN-1:0] e_pc, e_tgt;
        logic e_ready, e_valid;
        string tag;

        // in-order drain
        add_vec(0,0,0,1,'h100,'h200,1, 1,0,0,0,0);
        add_vec(0,0,0,1,'h104,'h300,1, 1,1,'h100,'h200,1);
        add_vec(0,0,0,0,0,0,1,         1,1,'h104,'h300,1);
        add_vec(0,0,0,0,0,0,0,         1,0,0,0,0);
        // coalescing
        add_vec(0,0,0,1,'h100,'h200,0, 1,0,0,0,0);
        add_vec(0,0,0,1,'h100,'h400,0, 1,0,0,0,1);
        add_vec(0,0,0,0,0,0,1,         1,1,'h100,'h400,1);
        add_vec(0,0,0,0,0,0,0,         1,0,0,0,0);
        // full, 5th offer ignored, drain in order
        add_vec(0,0,0,1,'h10,'h1000,0, 1,0,0,0,0);
        add_vec(0,0,0,1,'h20,'h2000,0, 1,0,0,0,1);
        add_vec(0,0,0,1,'h30,'h3000,0, 1,0,0,0,2);
        add_vec(0,0,0,1,'h40,'h4000,0, 1,0,0,0,3);
        add_vec(0,0,0,1,'h50,'h5000,0, 0,0,0,0,4);
        add_vec(0,0,0,1,'h50,'h5000,1, 0,1,'h10,'h1000,4);
        add_vec(0,0,0,0,0,0,1,         1,1,'h20,'h2000,3);
        add_vec(0,0,0,0,0,0,1,         1,1,'h30,'h3000,2);
        add_vec(0,0,0,0,0,0,1,         1,1,'h40,'h4000,1);
        add_vec(0,0,0,0,0,0,0,         1,0,0,0,0);
        // pop-match: head popping while the same pc is offered
        add_vec(0,0,0,1,'h100,'h200,0, 1,0,0,0,0);
        add_vec(0,0,0,1,'h100,'h500,1, 1,1,'h100,'h200,1);
        add_vec(0,0,0,0,0,0,1,         1,1,'h100,'h500,1);
        add_vec(0,0,0,0,0,0,0,         1,0,0,0,0);
        // full pc compare: bit 0 differs, so no coalescing
        add_vec(0,0,0,1,'h100,'h600,0, 1,0,0,0,0);
        add_vec(0,0,0,1,'h101,'h700,0, 1,0,0,0,1);
        add_vec(0,0,0,0,0,0,1,         1,1,'h100,'h600,2);
        add_vec(0,0,0,0,0,0,1,         1,1,'h101,'h700,1);
        // debug mode
        add_vec(0,0,1,1,'h100,'h200,1, 1,0,0,0,0);
        add_vec(0,0,0,0,0,0,1,         1,0,0,0,0);
        // flush with same-cycle offer
        add_vec(0,0,0,1,'h10,'h1000,0, 1,0,0,0,0);
        add_vec(0,0,0,1,'h20,'h2000,0, 1,0,0,0,1);
        add_vec(0,0,0,1,'h30,'h3000,0, 1,0,0,0,2);
        add_vec(0,1,0,1,'h40,'h4000,1, 1,0,0,0,3);
        add_vec(0,0,0,0,0,0,1,         1,0,0,0,0);
        // clear together with flush
        add_vec(0,0,0,1,'h60,'h6000,0, 1,0,0,0,0);
        add_vec(1,1,0,1,'h70,'h7000,1, 1,0,0,0,1);
        add_vec(0,0,0,0,0,0,1,         1,0,0,0,0);

        rst_ni = 1'b0;
        drive(0,0,0,0,0,0,0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_ready", VLEN'(resolve_ready_o), 1);
        check("reset_valid", VLEN'(btb_update_o.valid), 0);
        check("reset_occ",   VLEN'(occupancy_o), 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        exp_q.delete();

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].flush, vecs[i].dbg, vecs[i].rv,
                  vecs[i].pc, vecs[i].tgt, vecs[i].drain);
            @(negedge clk_i);
            tag = $sformatf("vec%0d", i);
            check({tag, "_ready"}, VLEN'(resolve_ready_o), VLEN'(vecs[i].e_ready));
            check({tag, "_valid"}, VLEN'(btb_update_o.valid), VLEN'(vecs[i].e_valid));
            check({tag, "_occ"},   VLEN'(occupancy_o), VLEN'(vecs[i].e_occ));
            if (vecs[i].e_valid) begin
                check({tag, "_pc"},  btb_update_o.pc, vecs[i].e_pc);
                check({tag, "_tgt"}, btb_update_o.target_address, vecs[i].e_tgt);
            end
            next_cycle();
        end

        // Randomized traffic with a mid-run asynchronous reset.
        exp_q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            drive($urandom_range(0,99) < 2, $urandom_range(0,99) < 3,
                  $urandom_range(0,99) < 8, $urandom_range(0,99) < 70,
                  VLEN'(64'h100 + 64'($urandom_range(0,5))),
                  {$urandom, $urandom}, $urandom_range(0,99) < 45);
            if (cyc == 400) begin
                rst_ni = 1'b0;
                #1;
                check("rnd_rst_ready", VLEN'(resolve_ready_o), 1);
                check("rnd_rst_valid", VLEN'(btb_update_o.valid), 0);
                check("rnd_rst_occ",   VLEN'(occupancy_o), 0);
                exp_q.delete();
                @(posedge clk_i);
                #1;
                rst_ni = 1'b1;
                continue;
            end
            @(negedge clk_i);
            e_ready = exp_q.size() < DEPTH;
            e_valid = (exp_q.size() != 0) && drain_en_i && !debug_mode_i && !flush_i && !clr_i;
            check("rnd_ready", VLEN'(resolve_ready_o), VLEN'(e_ready));
            check("rnd_valid", VLEN'(btb_update_o.valid), VLEN'(e_valid));
            check("rnd_occ",   VLEN'(occupancy_o), VLEN'(exp_q.size()));
            if (e_valid) begin
                e_pc  = exp_q[0][2*VLEN-1:VLEN];
                e_tgt = exp_q[0][VLEN-1:0];
                check("rnd_pc",  btb_update_o.pc, e_pc);
                check("rnd_tgt", btb_update_o.target_address, e_tgt);
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
